// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div : sequential restoring (shift-subtract) divider
//
// Divides a 2N-bit dividend by an N-bit divisor, producing one quotient bit
// per clock. Quotient and remainder share the working register ra:
// {partial remainder, dividend/quotient}.
//
// Ports
//   clk   in   1    rising-edge clock
//   rst   in   1    asynchronous reset, active-high
//   ld    in   1    load/start strobe (accepted in IDLE or DONE)
//   a     in   2N   dividend
//   b     in   N    divisor
//   ra    out  2N   working register {rem[2N-1:N], quo[N-1:0]}
//   rb    out  N    latched divisor
//   q     out  N    quotient  (ra[N-1:0]),  valid while done=1
//   r     out  N    remainder (ra[2N-1:N]), valid while done=1
//   busy  out  1    high while the shift-subtract loop runs
//   done  out  1    high while results are held, until the next accepted ld
//   ovf   out  1    quotient would not fit N bits
//   dz    out  1    divide by zero
// -----------------------------------------------------------------------------
module div #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] ra,
  output logic [N-1:0]   rb,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           busy,
  output logic           done,
  output logic           ovf,
  output logic           dz
);

  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W2-1:0] ra_nxt;
  logic [N-1:0]  rb_nxt;
  logic          ovf_nxt, dz_nxt;

  // Upper N+1 bits of ra shifted left by one: the trial minuend for this step.
  logic [N:0]    h;
  // Only the low N bits of h - rb are ever kept; while running, the partial
  // remainder is below rb, so the true difference always fits N bits.
  logic [N-1:0]  diff;

  assign h    = ra[W2-1:N-1];
  assign diff = h[N-1:0] - rb;

  assign q = ra[N-1:0];
  assign r = ra[W2-1:N];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ra    <= ra_nxt;
      rb    <= rb_nxt;
      ovf   <= ovf_nxt;
      dz    <= dz_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ra_nxt    = ra;
    rb_nxt    = rb;
    ovf_nxt   = ovf;
    dz_nxt    = dz;

    case (state)
      IDLE, DONE: begin
        if (ld) begin
          rb_nxt  = b;
          ra_nxt  = a;
          ovf_nxt = 1'b0;
          dz_nxt  = 1'b0;
          if (b == '0) begin
            dz_nxt    = 1'b1;
            ra_nxt    = '0;
            state_nxt = DONE;
          end else if (a[W2-1:N] >= b) begin
            // High half already >= divisor: quotient needs more than N bits.
            ovf_nxt   = 1'b1;
            ra_nxt    = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt   = CW'(N);
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        // Shift left; subtract and set the new quotient bit when it fits.
        if (h >= {1'b0, rb}) begin
          ra_nxt = {diff, ra[N-2:0], 1'b1};
        end else begin
          ra_nxt = {ra[W2-2:0], 1'b0};
        end
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div : directed self-checking bench for the restoring divider
// -----------------------------------------------------------------------------
module tb_div;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           ld;
  logic [2*N-1:0] a;
  logic [N-1:0]   b;
  logic [2*N-1:0] ra;
  logic [N-1:0]   rb;
  logic [N-1:0]   q;
  logic [N-1:0]   r;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dz;

  int total = 0;
  int bad   = 0;

  div #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld),
    .a    (a),
    .b    (b),
    .ra   (ra),
    .rb   (rb),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with a one-cycle ld strobe.
  task automatic start(input logic [2*N-1:0] av, input logic [N-1:0] bv);
    a  = av;
    b  = bv;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] qe, input logic [N-1:0] re,
                              input logic oe, input logic de);
    chk({tag, ".done"}, 16'(done), 16'd1);
    chk({tag, ".busy"}, 16'(busy), 16'd0);
    chk({tag, ".q"},    16'(q),    16'(qe));
    chk({tag, ".r"},    16'(r),    16'(re));
    chk({tag, ".ovf"},  16'(ovf),  16'(oe));
    chk({tag, ".dz"},   16'(dz),   16'(de));
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    ld  = 1'b0;
    a   = '0;
    b   = '0;
    tick();
    tick();
    chk("rst.ra",   16'(ra),   16'd0);
    chk("rst.rb",   16'(rb),   16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.ovf",  16'(ovf),  16'd0);
    chk("rst.dz",   16'(dz),   16'd0);
    rst = 1'b0;
    tick();

    // 143 / 11 = 13 r 0
    start(8'h8F, 4'hB);
    chk("t1.busy0", 16'(busy), 16'd1);
    chk("t1.done0", 16'(done), 16'd0);
    chk("t1.rb",    16'(rb),   16'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1.run_done", 16'(done), 16'd0);
    end
    tick();
    check_result("t1", 4'd13, 4'd0, 1'b0, 1'b0);
    chk("t1.ra", 16'(ra), 16'h000D);

    // 99 / 7 = 14 r 1, busy for exactly N cycles, done held afterwards
    start(8'd99, 4'd7);
    nb = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (busy) nb++;
      tick();
    end
    chk("t2.timeout", 16'(done), 16'd1);
    chk("t2.busy_cycles", 16'(nb), 16'd4);
    check_result("t2", 4'd14, 4'd1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("t2.hold_done", 16'(done), 16'd1);
    chk("t2.hold_q",    16'(q),    16'd14);
    chk("t2.hold_r",    16'(r),    16'd1);

    // Overflow early exits
    start(8'hB0, 4'hA);
    check_result("t3a", 4'd0, 4'd0, 1'b1, 1'b0);
    start(8'hFF, 4'hF);
    check_result("t3b", 4'd0, 4'd0, 1'b1, 1'b0);

    // Divide by zero, then a zero dividend clears dz
    start(8'h25, 4'h0);
    check_result("t4a", 4'd0, 4'd0, 1'b0, 1'b1);
    chk("t4a.ra", 16'(ra), 16'd0);
    start(8'h00, 4'h5);
    chk("t4b.busy", 16'(busy), 16'd1);
    chk("t4b.dz",   16'(dz),   16'd0);
    for (int i = 0; i < 4; i++) tick();
    check_result("t4b", 4'd0, 4'd0, 1'b0, 1'b0);

    // ld mid-run is ignored
    start(8'h8F, 4'hB);
    tick();
    a  = 8'hB0;
    b  = 4'h0;
    ld = 1'b1;
    tick();
    ld = 1'b0;
    chk("t5a.busy", 16'(busy), 16'd1);
    chk("t5a.rb",   16'(rb),   16'd11);
    tick();
    tick();
    check_result("t5a", 4'd13, 4'd0, 1'b0, 1'b0);

    // ld held high: accepted from DONE, ignored in RUN, restarts at DONE
    a  = 8'd99;
    b  = 4'd7;
    ld = 1'b1;
    tick();
    chk("t5b.busy", 16'(busy), 16'd1);
    for (int i = 0; i < 4; i++) tick();
    check_result("t5b", 4'd14, 4'd1, 1'b0, 1'b0);
    a = 8'h8F;
    b = 4'hB;
    tick();
    chk("t5c.busy", 16'(busy), 16'd1);
    chk("t5c.done", 16'(done), 16'd0);
    chk("t5c.rb",   16'(rb),   16'd11);
    ld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_result("t5c", 4'd13, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset during run, then a clean rerun
    start(8'h8F, 4'hB);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("t6.ra",   16'(ra),   16'd0);
    chk("t6.rb",   16'(rb),   16'd0);
    chk("t6.busy", 16'(busy), 16'd0);
    chk("t6.done", 16'(done), 16'd0);
    chk("t6.ovf",  16'(ovf),  16'd0);
    chk("t6.dz",   16'(dz),   16'd0);
    #2;
    rst = 1'b0;
    start(8'h8F, 4'hB);
    for (int i = 0; i < 4; i++) tick();
    check_result("t6r", 4'd13, 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
